// File: rtl/font_rom_arbiter.sv
// Round-robin share of one font ROM among NREQ overlay requesters; one lookup per clock.
// Response arrives two cycles after gnt; requesters hold req/addr until granted, with no stall on the response side.
module font_rom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 11,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] tag1_q, tag1_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;

    logic [PW:0]     scan_idx;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic [NREQ-1:0] gnt_raw;

    // Scan from ptr upward; the extra bit in scan_idx lets the wrap be a plain subtract.
    always_comb begin
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        gnt_raw   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (!win_found && req[scan_idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[PW-1:0];
            end
        end
        if (win_found) begin
            gnt_raw[win_idx] = 1'b1;
        end
    end

    assign gnt = reset ? '0 : gnt_raw;

    // AND-OR mux keyed on the one-hot grant: ungranted slices never reach the ROM.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            rom_addr = rom_addr | (req_addr[i*AW +: AW] & {AW{gnt[i]}});
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_found) begin
            ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_comb begin
        tag1_d      = gnt;
        rsp_valid_d = tag1_q;
        rsp_data_d  = (|tag1_q) ? rom_data : rsp_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            tag1_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag1_q      <= tag1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: directed vector table, reset corner sequences, randomized traffic vs a reference model.
module tb_font_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 11;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    font_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'h5A;
    endfunction

    // Synchronous font ROM: data valid the cycle after the address is sampled.
    always @(posedge clk) rom_data <= rom_f(rom_addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pointer as an integer, responses scheduled by cycle number.
    int              m_ptr;
    int              cyc;
    logic [NREQ-1:0] sch_v [8];
    logic [DW-1:0]   sch_d [8];
    logic [DW-1:0]   m_data;

    task automatic model_reset();
        m_ptr  = 0;
        m_data = '0;
        for (int i = 0; i < 8; i++) begin
            sch_v[i] = '0;
            sch_d[i] = '0;
        end
    endtask

    task automatic model_step(input bit pulse, output int w);
        int              slot;
        logic [AW-1:0]   ea;
        logic [NREQ-1:0] eg;
        if (pulse) begin
            reset = 1'b1;
            #1;
            chk("rst_gnt", gnt, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rom_addr", rom_addr, 0);
            reset = 1'b0;
            model_reset();
        end
        #1;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && req[idx]) w = idx;
        end
        eg = '0;
        ea = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ea    = req_addr[w*AW +: AW];
        end
        slot = cyc % 8;
        if (sch_v[slot] != 0) m_data = sch_d[slot];
        chk("gnt", gnt, eg);
        chk("rom_addr", rom_addr, ea);
        chk("rsp_valid", rsp_valid, sch_v[slot]);
        chk("rsp_data", rsp_data, m_data);
        sch_v[slot] = '0;
        if (w >= 0) begin
            sch_v[(cyc+2)%8] = eg;
            sch_d[(cyc+2)%8] = rom_f(ea);
            m_ptr = (w + 1) % NREQ;
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] rv;
    } vec_t;

    vec_t          tbl [17];
    logic [AW-1:0] fa  [NREQ];
    logic [AW-1:0] ga  [17];
    logic [DW-1:0] last_d;
    logic [AW-1:0] exp_a;
    int            w;
    bit            pend [NREQ];
    logic [AW-1:0] pa   [NREQ];
    int            wt   [NREQ];
    bit            do_rst;
    int            dens;

    initial begin
        // Rows run from a fresh reset with fixed addresses 0x100/0x200/0x305/0x400.
        tbl[0]  = '{4'b0100, 4'b0100, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b0100, 4'b0100};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b1000, 4'b0100};
        tbl[5]  = '{4'b1111, 4'b0001, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b0010, 4'b1000};
        tbl[7]  = '{4'b1111, 4'b0100, 4'b0001};
        tbl[8]  = '{4'b1111, 4'b1000, 4'b0010};
        tbl[9]  = '{4'b0100, 4'b0100, 4'b0100};
        tbl[10] = '{4'b0011, 4'b0001, 4'b1000};
        tbl[11] = '{4'b0011, 4'b0010, 4'b0100};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0001};
        tbl[13] = '{4'b0011, 4'b0001, 4'b0010};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0001};
        tbl[16] = '{4'b0000, 4'b0000, 4'b0000};
        fa[0] = 11'h100;
        fa[1] = 11'h200;
        fa[2] = 11'h305;
        fa[3] = 11'h400;

        reset = 1'b1;
        req   = '0;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = fa[i];
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First grant after release, then reset mid-clock with everyone requesting.
        req = 4'b1111;
        model_step(1'b0, w);
        chk("first_grant_idx", w, 0);
        model_step(1'b1, w);

        // Directed table from a clean reset.
        req   = '0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(negedge clk);
        last_d = '0;
        for (int k = 0; k < 17; k++) begin
            req = tbl[k].req;
            #1;
            exp_a = '0;
            for (int i = 0; i < NREQ; i++) if (tbl[k].gnt[i]) exp_a = fa[i];
            ga[k] = exp_a;
            if (tbl[k].rv != 0 && k >= 2) last_d = rom_f(ga[k-2]);
            chk($sformatf("tbl%0d_gnt", k), gnt, tbl[k].gnt);
            chk($sformatf("tbl%0d_rom_addr", k), rom_addr, exp_a);
            chk($sformatf("tbl%0d_rsp_valid", k), rsp_valid, tbl[k].rv);
            chk($sformatf("tbl%0d_rsp_data", k), rsp_data, last_d);
            @(negedge clk);
        end

        // Reset pulsed while a lookup is in flight: its response must vanish.
        req = '0;
        model_step(1'b1, w);
        req = 4'b0010;
        model_step(1'b0, w);
        req = 4'b0000;
        model_step(1'b1, w);
        req = 4'b1001;
        model_step(1'b0, w);
        chk("post_rst_grant_idx", w, 0);
        req = '0;
        model_step(1'b0, w);
        model_step(1'b0, w);

        // Randomized traffic obeying the hold-until-granted handshake.
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pa[i]   = '0;
            wt[i]   = 0;
        end
        for (int c = 0; c < 800; c++) begin
            dens = (c / 200) + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) < dens) begin
                    pend[i] = 1'b1;
                    pa[i]   = AW'($urandom);
                    wt[i]   = 0;
                end
                req[i] = pend[i];
                req_addr[i*AW +: AW] = pa[i];
            end
            do_rst = ($urandom_range(0, 99) == 0);
            if (do_rst) for (int i = 0; i < NREQ; i++) wt[i] = 0;
            model_step(do_rst, w);
            if (w >= 0) begin
                chk("fairness", (wt[w] <= NREQ - 1), 1);
                pend[w] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) if (pend[i]) wt[i]++;
        end
        req = '0;
        model_step(1'b0, w);
        model_step(1'b0, w);
        model_step(1'b0, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
